// File: rtl/mdu_sched_pkg.sv
// Shared definitions for the MDU scheduler: op and state encodings, latencies.
package mdu_sched_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam int MUL_LAT   = 5;   // busy cycles for a multiply
  localparam int DIV_ITERS = 32;  // one restoring step per cycle
  localparam int MUL_CNT_W = 3;
  localparam int DIV_CNT_W = 5;

  function automatic logic is_mul_class(input op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MADDU);
  endfunction

  function automatic logic is_div_class(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sched_div_iter.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle.
// quot_o/rem_o carry the result of the current step, so they hold the final
// answer in the cycle done_o is high and can be committed on that same edge.
module div_iter
  import mdu_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [31:0]          rem_q, quo_q, dvs_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic                 run_q;

  logic [32:0] trial;
  logic [33:0] diff;
  logic        ge;
  logic [31:0] rem_nx, quo_nx;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial  = {rem_q, quo_q[31]};
    diff   = {1'b0, trial} - {2'b00, dvs_q};
    ge     = ~diff[33];
    rem_nx = ge ? diff[31:0] : trial[31:0];
    quo_nx = {quo_q[30:0], ge};
  end

  assign done_o = run_q && (cnt_q == DIV_CNT_W'(DIV_ITERS - 1));
  assign quot_o = quo_nx;
  assign rem_o  = rem_nx;

  // Iteration registers: load on start, step while running, drop on abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (abort_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_sched.sv
// MDU scheduler: accepts one E-stage mult/div/move op at a time, sequences it,
// handles signs and commits to HI/LO; raises stall_d to hold D-stage MDU users.
// Handshake: an op is taken when op_valid_e & ~busy & ~int_req on a rising
// edge; upstream keeps it presented while stall_d holds the pipeline.
module mdu_sched
  import mdu_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid_e,
  input  logic [2:0]  op_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic        int_req,
  input  logic        mdu_use_d,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output state_t      dbg_state
);

  state_t               state_q, state_d;
  op_t                  op_q, op_d, op_in;
  logic [31:0]          rs_q, rs_d, rt_q, rt_d, hi_q, hi_d, lo_q, lo_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

  logic        accept, div_start, div_done, div_abort;
  logic [31:0] div_dvd, div_dvs, div_quot, div_rem, quot_fix, rem_fix;
  logic [63:0] mul_a, mul_b, prod, mul_res;

  assign op_in     = op_t'(op_e);
  assign busy      = (state_q != S_IDLE);
  assign accept    = op_valid_e & ~busy & ~int_req;
  assign stall_d   = mdu_use_d & (busy | (accept & (is_mul_class(op_in) | is_div_class(op_in))));
  assign div_start = accept & is_div_class(op_in);
  assign div_abort = int_req & (state_q == S_DIV);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

  // Divider sees magnitudes; signed DIV takes absolute values at acceptance.
  always_comb begin
    div_dvd = ((op_in == OP_DIV) && rs_e[31]) ? (~rs_e + 32'd1) : rs_e;
    div_dvs = ((op_in == OP_DIV) && rt_e[31]) ? (~rt_e + 32'd1) : rt_e;
  end

  div_iter u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .abort_i    (div_abort),
    .dividend_i (div_dvd),
    .divisor_i  (div_dvs),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  // Multiply on the latched operands; sign-extend for the signed variants.
  always_comb begin
    if ((op_q == OP_MULT) || (op_q == OP_MADD)) begin
      mul_a = {{32{rs_q[31]}}, rs_q};
      mul_b = {{32{rt_q[31]}}, rt_q};
    end else begin
      mul_a = {32'd0, rs_q};
      mul_b = {32'd0, rt_q};
    end
    prod    = mul_a * mul_b;
    mul_res = ((op_q == OP_MADD) || (op_q == OP_MADDU)) ? ({hi_q, lo_q} + prod) : prod;
  end

  // Restore signs: quotient by sign(rs)^sign(rt), remainder by sign(rs).
  always_comb begin
    quot_fix = ((op_q == OP_DIV) && (rs_q[31] ^ rt_q[31])) ? (~div_quot + 32'd1) : div_quot;
    rem_fix  = ((op_q == OP_DIV) && rs_q[31]) ? (~div_rem + 32'd1) : div_rem;
  end

  // Next-state logic: accept, count multiply latency, commit or abort.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = op_in;
          rs_d  = rs_e;
          rt_d  = rt_e;
          cnt_d = '0;
          if (is_mul_class(op_in))      state_d = S_MUL;
          else if (is_div_class(op_in)) state_d = S_DIV;
          else if (op_in == OP_MTHI)    hi_d = rs_e;
          else                          lo_d = rs_e;
        end
      end
      S_MUL: begin
        if (int_req) begin
          state_d = S_IDLE;
        end else if (cnt_q == MUL_CNT_W'(MUL_LAT - 1)) begin
          state_d = S_IDLE;
          hi_d    = mul_res[63:32];
          lo_d    = mul_res[31:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV: begin
        if (int_req) begin
          state_d = S_IDLE;
        end else if (div_done) begin
          state_d = S_IDLE;
          if (rt_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = rs_q;
          end else begin
            lo_d = quot_fix;
            hi_d = rem_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched operands and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      rs_q    <= '0;
      rt_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed cases then randomized ops,
// compared against an arithmetic model of HI/LO and expected busy lengths.
module tb_mdu_sched;
  import mdu_sched_pkg::*;

  logic        clk, reset, op_valid_e, int_req, mdu_use_d;
  logic [2:0]  op_e;
  logic [31:0] rs_e, rt_e;
  logic        busy, stall_d;
  logic [31:0] hi, lo;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  mdu_sched dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid_e (op_valid_e),
    .op_e       (op_e),
    .rs_e       (rs_e),
    .rt_e       (rt_e),
    .int_req    (int_req),
    .mdu_use_d  (mdu_use_d),
    .busy       (busy),
    .stall_d    (stall_d),
    .hi         (hi),
    .lo         (lo),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_busy(input logic [2:0] op);
    if (op == 3'd2 || op == 3'd3) return 32;
    if (op == 3'd6 || op == 3'd7) return 0;
    return 5;
  endfunction

  // Reference: architectural effect of one completed op on {m_hi, m_lo}.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      3'd0: begin p = sa * sb; {m_hi, m_lo} = p; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
      3'd4: begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + p; end
      3'd5: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = {m_hi, m_lo} + p; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (op == 3'd2) begin
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      3'd6: m_hi = a;
      default: m_lo = a;
    endcase
  endtask

  // Driver: present one op, scramble operands after acceptance, throw ignored
  // ops at the block while busy, then check busy length, stall and HI/LO.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input string tag);
    int n;
    int exp_n;
    exp_n = exp_busy(op);
    @(negedge clk);
    op_valid_e = 1'b1; op_e = op; rs_e = a; rt_e = b; mdu_use_d = use_d; int_req = 1'b0;
    #1 check({tag, " stall_accept"}, 64'(stall_d), 64'(use_d && exp_n != 0));
    @(negedge clk);
    op_valid_e = 1'b0; rs_e = $urandom; rt_e = $urandom;
    model(op, a, b);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      check({tag, " stall_busy"}, 64'(stall_d), 64'(use_d));
      op_valid_e = 1'($urandom_range(0, 1));
      op_e = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    op_valid_e = 1'b0;
    check({tag, " busy_cycles"}, 64'(n), 64'(exp_n));
    check({tag, " hi"}, 64'(hi), 64'(m_hi));
    check({tag, " lo"}, 64'(lo), 64'(m_lo));
  endtask

  // Start an op, pulse int_req at the given busy cycle, expect a clean abort.
  task automatic run_abort(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int at, input string tag);
    int n;
    @(negedge clk);
    op_valid_e = 1'b1; op_e = op; rs_e = a; rt_e = b; int_req = 1'b0;
    @(negedge clk);
    op_valid_e = 1'b0;
    n = 1;
    while (n < at) begin
      @(negedge clk);
      n++;
    end
    check({tag, " busy_before"}, 64'(busy), 64'd1);
    int_req = 1'b1;
    @(negedge clk);
    int_req = 1'b0;
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(m_hi));
    check({tag, " lo"}, 64'(lo), 64'(m_lo));
    repeat (40) @(negedge clk);
    check({tag, " hi_late"}, 64'(hi), 64'(m_hi));
    check({tag, " lo_late"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    // Reset
    reset = 1'b0; op_valid_e = 1'b0; op_e = 3'd0; rs_e = '0; rt_e = '0;
    int_req = 1'b0; mdu_use_d = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset stall", 64'(stall_d), 64'd0);
    check("reset state", 64'(dbg_state), 64'(S_IDLE));

    // First accept on the first edge after release
    reset = 1'b1; op_valid_e = 1'b1; op_e = 3'd7; rs_e = 32'h77;
    @(negedge clk);
    op_valid_e = 1'b0; m_lo = 32'h77;
    check("first_accept lo", 64'(lo), 64'h77);

    // Directed cases
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, "mult");
    check("mult hi const", 64'(hi), 64'hFFFF_FFFF);
    check("mult lo const", 64'(lo), 64'hFFFF_FFFA);
    run_op(3'd6, 32'd0, 32'd0, 1'b0, "mthi0");
    run_op(3'd7, 32'hFFFF_FFFF, 32'd0, 1'b0, "mtlo_ff");
    run_op(3'd5, 32'd1, 32'd1, 1'b1, "maddu");
    check("maddu hi const", 64'(hi), 64'd1);
    check("maddu lo const", 64'(lo), 64'd0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, "div_neg7");
    check("div_neg7 lo const", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg7 hi const", 64'(hi), 64'hFFFF_FFFF);
    run_op(3'd3, 32'h1234, 32'd0, 1'b0, "divu_zero");
    check("divu_zero lo const", 64'(lo), 64'hFFFF_FFFF);
    check("divu_zero hi const", 64'(hi), 64'h1234);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    check("div_ovf lo const", 64'(lo), 64'h8000_0000);
    check("div_ovf hi const", 64'(hi), 64'd0);
    run_op(3'd2, 32'h8000_0005, 32'd0, 1'b0, "div_zero");
    check("div_zero lo const", 64'(lo), 64'hFFFF_FFFF);
    check("div_zero hi const", 64'(hi), 64'h8000_0005);
    run_op(3'd4, 32'hFFFF_FFFF, 32'd7, 1'b0, "madd");
    run_op(3'd6, 32'hAA, 32'd0, 1'b0, "mthi_aa");
    run_abort(3'd2, 32'd1000, 32'd7, 10, "div_abort");
    check("div_abort hi const", 64'(hi), 64'hAA);
    run_abort(3'd0, 32'd9, 32'd9, 3, "mul_abort");
    run_op(3'd7, 32'h55, 32'd0, 1'b1, "mtlo_55");
    check("mtlo_55 lo const", 64'(lo), 64'h55);

    // int_req in the same cycle as a valid op blocks acceptance
    @(negedge clk);
    op_valid_e = 1'b1; op_e = 3'd0; rs_e = 32'd3; rt_e = 32'd3; int_req = 1'b1;
    @(negedge clk);
    op_valid_e = 1'b0; int_req = 1'b0;
    check("int_block busy", 64'(busy), 64'd0);
    repeat (8) @(negedge clk);
    check("int_block hi", 64'(hi), 64'(m_hi));
    check("int_block lo", 64'(lo), 64'(m_lo));

    // Reset in the middle of a multiply discards it
    run_op(3'd6, 32'hDEAD_BEEF, 32'd0, 1'b0, "mthi_pre_rst");
    @(negedge clk);
    op_valid_e = 1'b1; op_e = 3'd1; rs_e = 32'd100; rt_e = 32'd100;
    @(negedge clk);
    op_valid_e = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst hi_late", 64'(hi), 64'd0);
    check("midrst lo_late", 64'(lo), 64'd0);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 15) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
MDU_SCHED -- requirements
Module: mdu_sched

Interface
REQ-001 The block SHALL have the port `clk`, an input of width 1, which is the single clock; every register SHALL be updated on its rising edge.
REQ-002 The block SHALL have the port `reset`, an input of width 1, which is an asynchronous active-low reset.
REQ-003 The block SHALL have the port `op_valid_e`, an input of width 1, asserted when the E stage holds an MDU instruction.
REQ-004 The block SHALL have the port `op_e`, an input of width 3, with encodings: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MTHI, 7 MTLO.
REQ-005 The block SHALL have the ports `rs_e` and `rt_e`, inputs of width 32 each, carrying the forwarded E-stage operands.
REQ-006 The block SHALL have the port `int_req`, an input of width 1, which flushes the pipeline on an exception.
REQ-007 The block SHALL have the port `mdu_use_d`, an input of width 1, asserted when the D stage holds MFHI, MFLO or any MDU op.
REQ-008 The block SHALL have the port `busy`, an output of width 1, high while an operation is in flight.
REQ-009 The block SHALL have the port `stall_d`, an output of width 1, which is the stall request to the hazard logic.
REQ-010 The block SHALL have the ports `hi` and `lo`, outputs of width 32 each, which are the architectural HI/LO registers.

Function
REQ-011 An op SHALL be accepted when `op_valid_e` is high, `busy` is low and `int_req` is low; all other cycles SHALL leave state untouched.
REQ-012 State machine: IDLE, MUL, DIV; accepting MULT/MULTU/MADD/MADDU SHALL go to MUL, DIV/DIVU SHALL go to DIV, and MTHI/MTLO SHALL stay in IDLE.
REQ-013 MTHI/MTLO SHALL write `rs_e` into hi/lo at the accepting edge, with `busy` never asserting.
REQ-014 MUL SHALL last exactly 5 cycles after acceptance (`busy`=1 for 5 cycles); the result SHALL be committed to hi/lo on the edge that returns to IDLE.
REQ-015 DIV SHALL last exactly 32 cycles, one restoring iteration per cycle, on absolute values; the result SHALL be committed on the final edge.
REQ-016 Operands and the op SHALL be latched at acceptance; later changes on `rs_e`/`rt_e` SHALL have no effect.
REQ-017 MULT SHALL be signed 32x32->64 and MULTU unsigned; `hi` SHALL receive bits [63:32] and `lo` bits [31:0].
REQ-018 MADD/MADDU SHALL compute {hi,lo} plus the product, modulo 2^64, using the hi/lo values at acceptance.
REQ-019 DIV SHALL be signed: quotient sign = sign(rs) XOR sign(rt) and remainder sign = sign(rs); `lo` SHALL receive the quotient and `hi` the remainder.
REQ-020 For 0x80000000 / 0xFFFFFFFF, DIV SHALL yield lo=0x80000000 and hi=0.
REQ-021 For divide by zero, DIVU SHALL yield lo=0xFFFFFFFF and hi=rs.
REQ-022 For divide by zero, DIV SHALL yield lo=0xFFFFFFFF and hi=rs.
REQ-023 `int_req` high while busy SHALL abort the op: return to IDLE next edge, leave hi/lo unchanged and deassert `busy`.
REQ-024 `int_req` high in the same cycle as `op_valid_e` SHALL prevent acceptance.
REQ-025 `stall_d` SHALL equal `mdu_use_d` AND (`busy` OR an accept of MUL/DIV class this cycle).
REQ-026 `stall_d` SHALL be combinational.
REQ-027 On the commit cycle `busy` SHALL be 1, and it SHALL be 0 on the following cycle; back-to-back ops SHALL therefore have 1 idle cycle minimum.
REQ-028 An op with `op_valid_e` high while `busy` is high SHALL be ignored; it is held upstream by `stall_d`.

Reset
REQ-029 Reset low SHALL immediately force IDLE, `busy`=0, `hi`=0, `lo`=0, iteration counter 0, and latched operands 0.
REQ-030 Reset mid-operation SHALL discard the op with no commit.
REQ-031 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-032 The op encodings, state encodings, MUL latency (5) and DIV iteration count (32) SHALL reside in the shared header package used by the datapath.
REQ-033 The iterative divider SHALL be one sub-module `div_iter`, providing start/done, unsigned 32-bit operation and quotient/remainder outputs.
REQ-034 Sign handling and sequencing SHALL stay in `mdu_sched`.

Verification
REQ-035 MULT rs=0xFFFFFFFE, rt=3 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-036 Starting from hi=0, lo=0xFFFFFFFF, MADDU rs=1, rt=1 -> hi=1, lo=0.
REQ-037 DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, commit after 32 busy cycles.
REQ-038 DIVU rt=0, rs=0x1234 -> lo=0xFFFFFFFF, hi=0x1234.
REQ-039 DIV accepted with hi=0xAA, then `int_req` pulsed at busy cycle 10 -> busy=0 next cycle and hi stays 0xAA.
REQ-040 MTLO rs=0x55 with mdu_use_d=1 -> lo=0x55 next edge and stall_d never asserts.
